dmem_responder: RTL

Data-memory responder serving load/store requests issued by the EX-stage load/store unit of the Venus core. It holds a 64K x 32-bit word array and accepts at most one request per cycle on a valid/ready channel. Loads return read data on an in-order, back-pressurable response channel. A small response FIFO absorbs stalls from the consumer (MEM/WB side) without losing read data.

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_rsp_fifo.sv | 53 +++++
 rtl/dmem_responder.sv | 83 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the Venus data-memory responder.
package dmem_pkg;
    localparam int DMEM_AW    = 16;
    localparam int DMEM_DW    = 32;
    localparam int DMEM_DEPTH = 2 ** DMEM_AW;

    typedef logic [DMEM_DW-1:0] rsp_entry_t;
endpackage

// File: rtl/dmem_rsp_fifo.sv
// Response FIFO with an empty-bypass path: a pushed entry is visible at the head
// in the same cycle it is pushed, so load data appears one cycle after accept.
module dmem_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] entry_arr [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          empty, do_write, do_read;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_reg == '0);
    // Popping the bypassed entry consumes it before it is ever stored.
    assign do_write = push & ~(pop & empty);
    assign do_read  = pop & ~empty;
    assign valid    = ~empty | push;
    assign head     = ~empty ? entry_arr[rd_ptr_reg] : (push ? push_data : '0);
    assign count    = count_reg;

    always_ff @(posedge clk) begin
        if (do_write) begin
            entry_arr[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_write) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_read)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_reg + CW'(do_write) - CW'(do_read);
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with in-order, back-pressurable load responses.
// Define DMEM_WACK_EN to make every accepted store also return its write data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int AW         = DMEM_AW,
    parameter int DW         = DMEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DW-1:0] mem_arr [2 ** AW];
    logic [DW-1:0] rdata_reg;
    logic          inflight_reg;
    logic          accept, rsp_accept, pop;
    logic [DW-1:0] push_data;
    logic [CW-1:0] count;
    logic [CW:0]   occ_after_pop;

    assign accept = req_valid & req_ready;
    assign pop    = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            if (req_we) mem_arr[req_addr] <= req_wdata;
            else        rdata_reg         <= mem_arr[req_addr];
        end
    end

`ifdef DMEM_WACK_EN
    logic          wack_reg;
    logic [DW-1:0] wdata_reg;

    assign rsp_accept = accept;

    always_ff @(posedge clk) begin
        if (accept) begin
            wack_reg  <= req_we;
            wdata_reg <= req_wdata;
        end
    end

    assign push_data = wack_reg ? wdata_reg : rdata_reg;
`else
    assign rsp_accept = accept & ~req_we;
    assign push_data  = rdata_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) inflight_reg <= 1'b0;
        else     inflight_reg <= rsp_accept;
    end

    // Credit check counts the in-flight response and the pop happening now.
    assign occ_after_pop = {1'b0, count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
    assign req_ready     = ~rst & (occ_after_pop < (CW+1)'(FIFO_DEPTH));

    dmem_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_reg),
        .push_data (push_data),
        .pop       (pop),
        .valid     (rsp_valid),
        .head      (rsp_data),
        .count     (count)
    );
endmodule
